// File: rtl/fft_frame_scheduler_pkg.sv
// fft_sched_pkg: shared state encodings and default sizing for the frame scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fft_sched_pkg;

  localparam int ADDR_W_DEF  = 10;
  localparam int DATA_W_DEF  = 16;
  localparam int TIMEOUT_DEF = 4096;

  // Write FSM: filling a bank, or discarding whole frames while no bank is free.
  typedef logic [0:0] wstate_t;
  localparam wstate_t W_FILL = 1'b0;
  localparam wstate_t W_DROP = 1'b1;

  // Read FSM: waiting for a full bank, energy block owns a bank, one-cycle re-arm gap.
  typedef logic [1:0] rstate_t;
  localparam rstate_t R_IDLE = 2'd0;
  localparam rstate_t R_RUN  = 2'd1;
  localparam rstate_t R_GAP  = 2'd2;

endpackage

// File: rtl/fft_frame_scheduler_if.sv
// Bundles the FFT magnitude stream, BRAM write port, energy handshake and status flags.
// Latency: n/a (wiring only).
// Backpressure: none on the FFT stream; energy block paced by a ready/done level pair.
interface fft_frame_scheduler_if
  import fft_sched_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              fft_valid;
  logic              fft_last;
  logic [DATA_W-1:0] fft_data;
  logic              wr_en;
  logic              wr_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              energy_ready;
  logic              energy_done;
  logic              rd_bank;
  logic [7:0]        frame_cnt;
  logic              overrun;
  logic              len_err;
  logic              timeout_err;
  logic              clr_err;

  // Upstream/environment side: drives the stream, done and error clear.
  modport master (
    output fft_valid, fft_last, fft_data, energy_done, clr_err,
    input  wr_en, wr_bank, wr_addr, wr_data, energy_ready, rd_bank,
           frame_cnt, overrun, len_err, timeout_err
  );

  // Scheduler side.
  modport slave (
    input  fft_valid, fft_last, fft_data, energy_done, clr_err,
    output wr_en, wr_bank, wr_addr, wr_data, energy_ready, rd_bank,
           frame_cnt, overrun, len_err, timeout_err
  );
endinterface

// File: rtl/fft_frame_scheduler_watchdog.sv
// fft_sched_watchdog: counts cycles while enabled, pulses fire after TIMEOUT cycles.
// Latency: fire is combinational from the count; count restarts the cycle after enable drops.
// Backpressure: none; clear suppresses fire and restarts the count.
module fft_sched_watchdog #(
  parameter int TIMEOUT = 4096
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable,
  input  logic clear,
  output logic fire
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  // Count enabled cycles; saturate at the limit so fire cannot wrap back to silence.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (!enable || clear) begin
      cnt <= '0;
    end else if (cnt != LIMIT) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign fire = enable && !clear && (cnt == LIMIT);
endmodule

// File: rtl/fft_frame_scheduler.sv
// Ping-pong magnitude BRAM scheduler: FFT stream fills one bank while the energy block reads the other.
// Latency: fft beat -> BRAM write 1 cycle; fft_last -> energy_ready 2 cycles; energy_done -> ready low 1 cycle.
// Backpressure: none on FFT input; whole frames are dropped (overrun) when no bank is free.
// Optional watchdog on the read side: FFT_SCHED_WATCHDOG_EN.
module fft_frame_scheduler
  import fft_sched_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic                 clock,
  input logic                 reset_n,
  fft_frame_scheduler_if.slave bus
);
  localparam logic [ADDR_W-1:0] WCNT_MAX = '1;

  wstate_t           wstate;
  rstate_t           rstate;
  logic              wbank;
  logic              next_rd;
  logic              drop_mid;
  logic [1:0]        full;
  logic [ADDR_W-1:0] wcnt;

  logic              wr_en_q;
  logic              wr_bank_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              ready_q;
  logic              rd_bank_q;
  logic [7:0]        frame_cnt_q;
  logic              overrun_q;
  logic              len_err_q;

  logic       wd_fire;
  logic       rel;
  logic [1:0] rel_mask;
  logic [1:0] set_mask;
  logic [1:0] free;
  logic       beat;
  logic       drop_mid_n;
  logic       pick;
  logic       len_set;
  logic       overrun_set;

`ifdef FFT_SCHED_WATCHDOG_EN
  logic timeout_q;

  fft_sched_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (rstate == R_RUN),
    .clear   (bus.energy_done),
    .fire    (wd_fire)
  );

  // Sticky timeout flag; a fire in the same cycle as clr_err wins.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) timeout_q <= 1'b0;
    else          timeout_q <= wd_fire | (timeout_q & ~bus.clr_err);
  end

  assign bus.timeout_err = timeout_q;
`else
  assign wd_fire         = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  // A bank released this cycle counts as free for the writer.
  assign rel         = (rstate == R_RUN) && (bus.energy_done || wd_fire);
  assign rel_mask    = rel ? (rd_bank_q ? 2'b10 : 2'b01) : 2'b00;
  assign free        = ~full | rel_mask;
  assign beat        = bus.fft_valid;
  assign set_mask    = (wstate == W_FILL && beat && bus.fft_last) ? (wbank ? 2'b10 : 2'b01) : 2'b00;
  assign drop_mid_n  = beat ? !bus.fft_last : drop_mid;
  assign pick        = full[next_rd] ? next_rd : ~next_rd;
  assign len_set     = (wstate == W_FILL) && beat && (wcnt == WCNT_MAX);
  assign overrun_set = (wstate == W_DROP) && beat && !drop_mid;

  // Write FSM: register beats into the current bank, choose the next bank at each frame end.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wstate    <= W_FILL;
      wbank     <= 1'b0;
      wcnt      <= '0;
      drop_mid  <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_bank_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= 1'b0;
      if (wstate == W_FILL) begin
        if (beat) begin
          if (wcnt != WCNT_MAX) begin
            wr_en_q   <= 1'b1;
            wr_bank_q <= wbank;
            wr_addr_q <= wcnt;
            wr_data_q <= bus.fft_data;
            wcnt      <= wcnt + ADDR_W'(1);
          end
          if (bus.fft_last) begin
            wcnt <= '0;
            if (free[~wbank]) wbank  <= ~wbank;
            else              wstate <= W_DROP;
          end
        end
      end else begin
        drop_mid <= drop_mid_n;
        // Resume only between frames; keep bank alternation when both are free.
        if (!drop_mid_n && (|free)) begin
          wstate <= W_FILL;
          wbank  <= free[~wbank] ? ~wbank : wbank;
        end
      end
    end
  end

  // Bank occupancy: set on the frame's last write, cleared when the reader releases it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) full <= 2'b00;
    else          full <= (full & ~rel_mask) | set_mask;
  end

  // Read FSM: hand the oldest full bank to the energy block, release on done, then re-arm gap.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rstate      <= R_IDLE;
      next_rd     <= 1'b0;
      rd_bank_q   <= 1'b0;
      ready_q     <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (|full) begin
            rd_bank_q   <= pick;
            next_rd     <= ~pick;
            ready_q     <= 1'b1;
            frame_cnt_q <= frame_cnt_q + 8'd1;
            rstate      <= R_RUN;
          end
        end
        R_RUN: begin
          if (rel) begin
            ready_q <= 1'b0;
            rstate  <= R_GAP;
          end
        end
        R_GAP:   rstate <= R_IDLE;
        default: rstate <= R_IDLE;
      endcase
    end
  end

  // Sticky error flags; a set in the same cycle as clr_err wins.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overrun_q <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      overrun_q <= overrun_set | (overrun_q & ~bus.clr_err);
      len_err_q <= len_set | (len_err_q & ~bus.clr_err);
    end
  end

  assign bus.wr_en        = wr_en_q;
  assign bus.wr_bank      = wr_bank_q;
  assign bus.wr_addr      = wr_addr_q;
  assign bus.wr_data      = wr_data_q;
  assign bus.energy_ready = ready_q;
  assign bus.rd_bank      = rd_bank_q;
  assign bus.frame_cnt    = frame_cnt_q;
  assign bus.overrun      = overrun_q;
  assign bus.len_err      = len_err_q;
endmodule

// File: doc/fft_frame_scheduler.md
# fft_frame_scheduler

Sequences the FFT-energy datapath per audio frame. Owns a two-bank (ping-pong) magnitude BRAM: the FFT output stream fills one bank while the energy/colour block reads the other. Generates that block's `ready` level handshake, selects its read bank, and drops whole frames when no bank is free.

## Interface
- `ADDR_W`, 10, bank address width; bank depth 2^ADDR_W.
- `DATA_W`, 16, magnitude sample width.
- `TIMEOUT`, 4096, watchdog limit in cycles (used only with the watchdog macro).

- `clock`  in  1  system clock, all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `fft_valid`  in  1  magnitude beat valid; no backpressure.
- `fft_last`  in  1  last beat of frame, qualified by `fft_valid`.
- `fft_data`  in  DATA_W  magnitude beat.
- `wr_en`  out  1  BRAM write strobe.
- `wr_bank`  out  1  bank being written.
- `wr_addr`  out  ADDR_W  write address within bank.
- `wr_data`  out  DATA_W  registered `fft_data`.
- `energy_ready`  out  1  level to energy block; high while it owns `rd_bank`.
- `energy_done`  in  1  energy block finished current bank.
- `rd_bank`  out  1  bank the energy block reads.
- `frame_cnt`  out  8  frames handed off, wraps.
- `overrun`  out  1  sticky: a frame was dropped.
- `len_err`  out  1  sticky: frame exceeded bank depth.
- `timeout_err`  out  1  sticky: watchdog fired.
- `clr_err`  in  1  pulse, clears all three sticky flags.

## Operation
- Bank status `full[1:0]`; a bank is full from its `fft_last` write until the reader releases it.
- Write FSM: W_FILL, W_DROP.
  - W_FILL: each `fft_valid` beat writes `wbank` at `wcnt`, `wcnt++`. At `wcnt` = 2^ADDR_W-1 further beats are discarded, `len_err` set; `wcnt` does not wrap.
  - On `fft_last`: `full[wbank]`<=1, `wcnt`<=0. If `~wbank` is free (counting a release in the same cycle as free) flip `wbank`, stay W_FILL; else go W_DROP.
  - W_DROP: no writes. Each frame whose first beat arrives here is discarded until its `fft_last`; `overrun` set per dropped frame. Return to W_FILL, with `wbank` = the free bank, only at a frame boundary (after a `fft_last`, or immediately if no frame in progress) once a bank is free.
- Read FSM: R_IDLE, R_RUN, R_GAP.
  - R_IDLE: if any bank full, pick oldest (`next_rd`, toggles per handoff), `rd_bank`<=it, `energy_ready`<=1, `frame_cnt++`, go R_RUN.
  - R_RUN: hold `energy_ready`=1, `rd_bank` stable. On `energy_done`=1: `full[rd_bank]`<=0, `energy_ready`<=0, go R_GAP.
  - R_GAP: one cycle with `energy_ready`=0 (energy block re-arms on low `ready`), then R_IDLE.
- `clr_err` and a same-cycle set: set wins.
- Reset values: all outputs 0, `wbank`=0, `next_rd`=0, `full`=0, W_FILL, R_IDLE.

## Timing
- Write path: `fft_*` sampled at edge N, `wr_en/wr_addr/wr_data` valid N+1.
- Handoff: `fft_last` at N -> `full` at N+1 -> `energy_ready` high at N+2 if reader idle.
- `energy_done` at N -> `energy_ready` low N+1, bank writable by W_FILL from N+1; earliest next `energy_ready` N+3.
- `energy_done` in R_IDLE/R_GAP ignored.
- Reset asserted mid-frame: partial frame discarded, all status cleared immediately.

## Configuration
- `FFT_SCHED_WATCHDOG_EN` defined: cycle counter in R_RUN; reaching `TIMEOUT` without `energy_done` behaves as `energy_done` (bank released, R_GAP) and sets `timeout_err`.
- Undefined: R_RUN waits indefinitely; `timeout_err` tied 0, no counter logic.

## Structure
- `fft_sched_pkg`: write/read state enums, default `ADDR_W`/`DATA_W`/`TIMEOUT`.
- One sub-module `fft_sched_watchdog` (enable, clear, fire pulse), instantiated only under the macro.

## Test plan
- 1 frame of 8 beats, `energy_done` 20 cycles after ready -> bank0 addrs 0..7, `energy_ready` rises 2 cycles after last, `rd_bank`=0, `frame_cnt`=1.
- Three back-to-back frames, done never returned -> frames 1,2 fill banks 0,1; frame 3 dropped, `overrun`=1, no `wr_en` during it.
- `fft_last` on same cycle as `energy_done` for other bank -> `wbank` flips, no drop, `overrun`=0.
- Frame of 1030 beats with ADDR_W=10 -> 1023 writes, `len_err`=1, frame still handed off.
- Watchdog build, TIMEOUT=16, done withheld -> `energy_ready` low after 16 cycles, `timeout_err`=1; `clr_err` clears it.
- `reset_n` low mid-frame -> all outputs 0 same cycle; next full frame lands in bank0 from addr 0.
